tnew_scoreboard: RTL and testbench

- Producer-side half of the hazard unit; the per-source Tuse/used decoders in ID are the consumer side.
- Holds, for every in-flight instruction in E, M and W, its destination register and remaining Tnew (cycles until its result is forwardable).
- Each cycle compares that state against the rs/rt Tuse of the instruction in ID, then drives the pipeline stall and the ID-stage forward selects.
- Keeps a saturating count of stall cycles for performance checks.

---
 rtl/tnew_scoreboard.sv | 89 ++++++++
 tb/tb_tnew_scoreboard.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tnew_scoreboard.sv
// Producer-side hazard scoreboard: tracks dst/Tnew of E, M and W and resolves ID stall and forward selects.
// Stall and forward selects are combinational from current state; state advances every edge with no backpressure input.
module tnew_scoreboard #(
  parameter int REG_W = 5,
  parameter int T_W   = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_dst,
  input  logic [T_W-1:0]   id_tnew,
  input  logic             rs_used,
  input  logic [REG_W-1:0] rs_addr,
  input  logic [T_W-1:0]   rs_tuse,
  input  logic             rt_used,
  input  logic [REG_W-1:0] rt_addr,
  input  logic [T_W-1:0]   rt_tuse,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       rs_fwd,
  output logic [1:0]       rt_fwd,
  output logic [CNT_W-1:0] stall_cnt
);

  // index 0 = E, 1 = M, 2 = W
  logic [2:0]       vld;
  logic [REG_W-1:0] dst  [3];
  logic [T_W-1:0]   tnew [3];

  logic [1:0]       s_used;
  logic [REG_W-1:0] s_addr [2];
  logic [T_W-1:0]   s_tuse [2];
  logic [1:0]       s_stall;
  logic [1:0]       s_fwd  [2];

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    return (x == '0) ? '0 : x - T_W'(1);
  endfunction

  assign s_used    = {rt_used, rs_used};
  assign s_addr[0] = rs_addr;
  assign s_addr[1] = rt_addr;
  assign s_tuse[0] = rs_tuse;
  assign s_tuse[1] = rt_tuse;

  // Walk W -> E so the youngest matching stage is the one left standing.
  always_comb begin
    s_stall  = '0;
    s_fwd[0] = 2'b00;
    s_fwd[1] = 2'b00;
    for (int s = 0; s < 2; s++) begin
      if (s_used[s] && s_addr[s] != '0) begin
        for (int i = 2; i >= 0; i--) begin
          if (vld[i] && dst[i] == s_addr[s]) begin
            s_stall[s] = tnew[i] > s_tuse[s];
            s_fwd[s]   = (tnew[i] == '0) ? 2'(i + 1) : 2'b00;
          end
        end
      end
    end
  end

  assign stall  = id_valid & (|s_stall);
  assign rs_fwd = (stall | flush) ? 2'b00 : s_fwd[0];
  assign rt_fwd = (stall | flush) ? 2'b00 : s_fwd[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        dst[i]  <= '0;
        tnew[i] <= '0;
      end
    end else begin
      vld     <= flush ? 3'b000 : {vld[1], vld[0], id_valid & ~stall};
      dst[2]  <= dst[1];
      dst[1]  <= dst[0];
      dst[0]  <= id_dst;
      tnew[2] <= sat_dec(tnew[1]);
      tnew[1] <= sat_dec(tnew[0]);
      tnew[0] <= id_tnew;
      if (stall && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tnew_scoreboard.sv
// Scoreboard bench for tnew_scoreboard: expected outputs queued with each stimulus cycle, popped and compared once settled.
module tb_tnew_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_dst;
  logic [1:0]  id_tnew;
  logic        rs_used;
  logic [4:0]  rs_addr;
  logic [1:0]  rs_tuse;
  logic        rt_used;
  logic [4:0]  rt_addr;
  logic [1:0]  rt_tuse;
  logic        flush;
  logic        stall;
  logic [1:0]  rs_fwd;
  logic [1:0]  rt_fwd;
  logic [31:0] stall_cnt;

  // narrow-counter instance for saturation
  logic        sat_valid;
  logic [4:0]  sat_dst;
  logic [1:0]  sat_tnew;
  logic        sat_rs_used;
  logic [4:0]  sat_rs_addr;
  logic [1:0]  sat_rs_tuse;
  logic        sat_zero;
  logic [4:0]  sat_zero_addr;
  logic [1:0]  sat_zero_t;
  logic        sat_stall;
  logic [1:0]  sat_rs_fwd;
  logic [1:0]  sat_rt_fwd;
  logic [2:0]  sat_cnt;

  typedef struct packed {
    logic        stall;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks;
  int    n_fails;

  tnew_scoreboard #(.REG_W(5), .T_W(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_dst(id_dst), .id_tnew(id_tnew),
    .rs_used(rs_used), .rs_addr(rs_addr), .rs_tuse(rs_tuse),
    .rt_used(rt_used), .rt_addr(rt_addr), .rt_tuse(rt_tuse),
    .flush(flush), .stall(stall), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .stall_cnt(stall_cnt)
  );

  tnew_scoreboard #(.REG_W(5), .T_W(2), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(sat_valid), .id_dst(sat_dst), .id_tnew(sat_tnew),
    .rs_used(sat_rs_used), .rs_addr(sat_rs_addr), .rs_tuse(sat_rs_tuse),
    .rt_used(sat_zero), .rt_addr(sat_zero_addr), .rt_tuse(sat_zero_t),
    .flush(sat_zero), .stall(sat_stall), .rs_fwd(sat_rs_fwd), .rt_fwd(sat_rt_fwd), .stall_cnt(sat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic es, input logic [1:0] ers,
                            input logic [1:0] ert, input logic [31:0] ecnt);
    exp_t e;
    e.stall = es;
    e.rs    = ers;
    e.rt    = ert;
    e.cnt   = ecnt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".stall"}, {31'b0, stall}, {31'b0, e.stall});
    check({t, ".rs_fwd"}, {30'b0, rs_fwd}, {30'b0, e.rs});
    check({t, ".rt_fwd"}, {30'b0, rt_fwd}, {30'b0, e.rt});
    check({t, ".cnt"}, stall_cnt, e.cnt);
  endtask

  task automatic compare_sat();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".cnt"}, {29'b0, sat_cnt}, e.cnt);
  endtask

  // One pipeline cycle: drive ID in the low phase, compare before the next rising edge.
  task automatic cyc(input string tag, input logic v, input logic [4:0] d, input logic [1:0] tn,
                     input logic su, input logic [4:0] sa, input logic [1:0] st,
                     input logic tu, input logic [4:0] ta, input logic [1:0] tt, input logic fl,
                     input logic es, input logic [1:0] ers, input logic [1:0] ert,
                     input logic [31:0] ecnt);
    @(negedge clk);
    id_valid = v;  id_dst  = d;  id_tnew = tn;
    rs_used  = su; rs_addr = sa; rs_tuse = st;
    rt_used  = tu; rt_addr = ta; rt_tuse = tt;
    flush    = fl;
    expect_out(tag, es, ers, ert, ecnt);
    #2;
    compare_out();
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_dst = 0; id_tnew = 0;
    rs_used = 0; rs_addr = 0; rs_tuse = 0;
    rt_used = 0; rt_addr = 0; rt_tuse = 0;
    flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    idle_inputs();
    sat_valid = 0; sat_dst = 0; sat_tnew = 0;
    sat_rs_used = 0; sat_rs_addr = 0; sat_rs_tuse = 0;
    sat_zero = 0; sat_zero_addr = 0; sat_zero_t = 0;

    #12;
    expect_out("reset", 1'b0, 2'b00, 2'b00, 32'd0);
    compare_out();
    @(negedge clk);
    rst_n = 1'b1;

    // ALU then dependent beq: one stall, then forward from M
    cyc("t1_alu",       1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("t1_beq_stall", 1, 0, 0, 1, 8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
    cyc("t1_beq_fwd",   1, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1);

    // lw then add consuming rt with tuse 1
    do_reset();
    cyc("t2_lw",        1, 9,  2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("t2_add_stall", 1, 10, 1, 0, 0, 0, 1, 9, 1, 0, 1, 2'b00, 2'b00, 0);
    cyc("t2_add_go",    1, 10, 1, 0, 0, 0, 1, 9, 1, 0, 0, 2'b00, 2'b00, 1);
    cyc("t2_cnt",       0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);

    // jal/jr forward from E; flush forces selects to GRF
    do_reset();
    cyc("t3_jal",       1, 31, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("t3_jr",        1, 0,  0, 1, 31, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0);
    cyc("t3_flush_fwd", 1, 0,  0, 1, 31, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0);

    // youngest match wins; unused or r0 sources never match
    do_reset();
    cyc("t4_first",     1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("t4_unused",    1, 5, 0, 0, 5, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("t4_young",     1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0);
    cyc("t4_r0",        1, 0, 0, 1, 0, 0, 1, 5, 0, 0, 0, 2'b00, 2'b10, 0);

    // lw/sw with late tuse; flush over a pending stall
    do_reset();
    cyc("t5_lw",        1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("t5_sw",        1, 0, 0, 0, 0, 0, 1, 4, 2, 0, 0, 2'b00, 2'b00, 0);
    cyc("t5_flush",     1, 0, 0, 1, 4, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0);
    cyc("t5_after",     1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    // bubble in ID never stalls; async reset in the middle of a stall
    do_reset();
    cyc("t6_ld",        1, 9, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("t6_bubble",    0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc("t6_s1",        1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
    cyc("t6_s2",        1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1);
    rst_n = 1'b0;
    #1;
    expect_out("t6_async_rst", 1'b0, 2'b00, 2'b00, 32'd0);
    compare_out();
    @(negedge clk);
    rst_n = 1'b1;

    // 3-bit counter: 3 stalls per 4 cycles, 6 after 8 edges, pinned at 7 later
    do_reset();
    idle_inputs();
    sat_valid = 1; sat_dst = 3; sat_tnew = 3;
    sat_rs_used = 1; sat_rs_addr = 3; sat_rs_tuse = 0;
    repeat (8) @(posedge clk);
    #1;
    expect_out("sat_8", 1'b0, 2'b00, 2'b00, 32'd6);
    compare_sat();
    repeat (8) @(posedge clk);
    #1;
    expect_out("sat_16", 1'b0, 2'b00, 2'b00, 32'd7);
    compare_sat();

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
